// File: rtl/excess4bit_seq_ctrl.sv
// Frame sequencer for the serial excess-3 converter: BCD digits in, 4-clock serial frames out,
// sampled results back through a 2-deep FWFT FIFO. Optional BCD range check: BCD_RANGE_CHECK_EN.
//
// state      | meaning
// IDLE_FRAME | current 4-clock frame drives ser_x = 0, result discarded
// DATA_FRAME | current frame serialises the loaded digit, result captured
module excess4bit_seq_ctrl #(
  parameter int MSB_FIRST = 0,
  parameter int Z_LAT     = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_digit,
  output logic             ser_x,
  output logic [1:0]       ser_phase,
  input  logic [3:0]       ser_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_z,
  output logic             out_err,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic {IDLE_FRAME, DATA_FRAME} frame_e;

  localparam logic [1:0] CAP_PHASE = 2'(Z_LAT);

  frame_e           frame_q, frame_d;
  logic [1:0]       phase_q, phase_d;
  logic [3:0]       digit_q, digit_d;
  logic             err_cur_q, err_cur_d;
  logic             prev_data_q, prev_data_d;
  logic             prev_err_q, prev_err_d;
  logic             ser_x_q, ser_x_d;
  logic [1:0]       credits_q, credits_d;
  logic [1:0][4:0]  mem_q, mem_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic accept, push, pop, err_in;

`ifdef BCD_RANGE_CHECK_EN
  assign err_in = (in_digit > 4'd9);
`else
  assign err_in = 1'b0;
`endif

  function automatic logic pick_bit(input logic [3:0] d, input logic [1:0] p);
    return (MSB_FIRST != 0) ? d[2'd3 - p] : d[p];
  endfunction

  assign in_ready  = (phase_q == 2'd3) && (credits_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  // The previous frame's tag is still valid here: capture lands Z_LAT+1 clocks past its last bit.
  assign push      = prev_data_q && (phase_q == CAP_PHASE);

  always_comb begin
    phase_d     = phase_q + 2'd1;
    frame_d     = frame_q;
    digit_d     = digit_q;
    err_cur_d   = err_cur_q;
    prev_data_d = prev_data_q;
    prev_err_d  = prev_err_q;
    ser_x_d     = 1'b0;
    if (phase_q == 2'd3) begin
      prev_data_d = (frame_q == DATA_FRAME);
      prev_err_d  = err_cur_q;
      if (accept) begin
        frame_d   = DATA_FRAME;
        digit_d   = in_digit;
        err_cur_d = err_in;
        ser_x_d   = pick_bit(in_digit, 2'd0);
      end else begin
        frame_d   = IDLE_FRAME;
        err_cur_d = 1'b0;
      end
    end else if (frame_q == DATA_FRAME) begin
      ser_x_d = pick_bit(digit_q, phase_d);
    end
  end

  always_comb begin
    credits_d  = credits_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    cnt_d      = cnt_q;
    done_cnt_d = done_cnt_q;
    if (accept && !pop) credits_d = credits_q - 2'd1;
    else if (!accept && pop) credits_d = credits_q + 2'd1;
    if (push) mem_d[wr_ptr_q] = {prev_err_q, ser_z};
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (pop) done_cnt_d = done_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q     <= IDLE_FRAME;
      phase_q     <= 2'd0;
      digit_q     <= 4'd0;
      err_cur_q   <= 1'b0;
      prev_data_q <= 1'b0;
      prev_err_q  <= 1'b0;
      ser_x_q     <= 1'b0;
      credits_q   <= 2'd2;
      mem_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      done_cnt_q  <= '0;
    end else begin
      frame_q     <= frame_d;
      phase_q     <= phase_d;
      digit_q     <= digit_d;
      err_cur_q   <= err_cur_d;
      prev_data_q <= prev_data_d;
      prev_err_q  <= prev_err_d;
      ser_x_q     <= ser_x_d;
      credits_q   <= credits_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign ser_x     = ser_x_q;
  assign ser_phase = phase_q;
  assign done_cnt  = done_cnt_q;
  assign out_z     = out_valid ? mem_q[rd_ptr_q][3:0] : 4'd0;
  assign out_err   = out_valid && mem_q[rd_ptr_q][4];

endmodule

// File: tb/tb_excess4bit_seq_ctrl.sv
// Directed bench for excess4bit_seq_ctrl with a behavioural excess-3 converter on ser_x/ser_z.
module tb_excess4bit_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_digit = 4'd0;
  logic       ser_x;
  logic [1:0] ser_phase;
  logic [3:0] ser_z;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_z;
  logic       out_err;
  logic [7:0] done_cnt;

  int tests_run = 0;
  int failed = 0;

  excess4bit_seq_ctrl #(.MSB_FIRST(0), .Z_LAT(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
    .ser_x(ser_x), .ser_phase(ser_phase), .ser_z(ser_z), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_err(out_err), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Reference frame counter and converter: collects bits LSB first, outputs value+3 after bit 3.
  logic [1:0] tb_phase;
  logic [3:0] cv_sh, cv_z;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tb_phase <= 2'd0;
      cv_sh    <= 4'd0;
      cv_z     <= 4'd0;
    end else begin
      tb_phase        <= tb_phase + 2'd1;
      cv_sh[tb_phase] <= ser_x;
      if (tb_phase == 2'd3) cv_z <= {ser_x, cv_sh[2:0]} + 4'd3;
    end
  end
  assign ser_z = cv_z;

  logic       collect = 1'b0;
  logic [3:0] res_q[$];
  always @(negedge clk) if (collect && out_valid) res_q.push_back(out_z);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input logic [1:0] p);
    for (int n = 0; n < 8 && tb_phase != p; n++) @(negedge clk);
    chk("wait_phase", 32'(ser_phase), 32'(p));
  endtask

  logic exp_err12;

  initial begin
`ifdef BCD_RANGE_CHECK_EN
    exp_err12 = 1'b1;
`else
    exp_err12 = 1'b0;
`endif
    #22;
    chk("rst_phase", 32'(ser_phase), 32'd0);
    chk("rst_ser_x", 32'(ser_x), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // 1: idle frames
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("t1_ser_x", 32'(ser_x), 32'd0);
      chk("t1_out_valid", 32'(out_valid), 32'd0);
      chk("t1_phase", 32'(ser_phase), 32'(i % 4));
    end
    chk("t1_done_cnt", 32'(done_cnt), 32'd0);

    // 2: single digit 5 -> bits 1,0,1,0 and out_z 8 six clocks after accept
    wait_phase(2'd3);
    in_valid = 1'b1; in_digit = 4'd5;
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 1) chk("t2_bit0", 32'(ser_x), 32'd1);
      if (k == 2) chk("t2_bit1", 32'(ser_x), 32'd0);
      if (k == 3) chk("t2_bit2", 32'(ser_x), 32'd1);
      if (k == 4) chk("t2_bit3", 32'(ser_x), 32'd0);
      if (k == 5) chk("t2_idle_bit", 32'(ser_x), 32'd0);
      if (k == 6) chk("t2_not_yet", 32'(out_valid), 32'd0);
      if (k == 7) begin
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_z", 32'(out_z), 32'd8);
        chk("t2_out_err", 32'(out_err), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_popped", 32'(out_valid), 32'd0);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // 3: stream 0..9 back to back
    collect = 1'b1;
    for (int d = 0; d < 10; d++) begin
      wait_phase(2'd3);
      in_valid = 1'b1; in_digit = 4'(d);
      chk("t3_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
    end
    repeat (8) @(negedge clk);
    collect = 1'b0;
    chk("t3_count", 32'(res_q.size()), 32'd10);
    for (int i = 0; i < res_q.size(); i++) chk("t3_out_z", 32'(res_q[i]), 32'(i + 3));
    chk("t3_done_cnt", 32'(done_cnt), 32'd11);

    // 4: backpressure, credits cap at two
    out_ready = 1'b0;
    in_valid = 1'b1; in_digit = 4'd1;
    wait_phase(2'd3);
    chk("t4_acc1", 32'(in_ready), 32'd1);
    @(negedge clk); in_digit = 4'd2;
    wait_phase(2'd3);
    chk("t4_acc2", 32'(in_ready), 32'd1);
    @(negedge clk); in_digit = 4'd3;
    wait_phase(2'd3);
    chk("t4_block1", 32'(in_ready), 32'd0);
    @(negedge clk);
    wait_phase(2'd3);
    chk("t4_block2", 32'(in_ready), 32'd0);
    chk("t4_full_valid", 32'(out_valid), 32'd1);
    chk("t4_head_z", 32'(out_z), 32'd4);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("t4_done_cnt", 32'(done_cnt), 32'd12);
    chk("t4_head2_z", 32'(out_z), 32'd5);
    wait_phase(2'd3);
    chk("t4_acc3", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("t4_drained", 32'(out_valid), 32'd0);
    chk("t4_done_cnt2", 32'(done_cnt), 32'd13);
    repeat (4) @(negedge clk);
    chk("t4_lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t4_lat_valid", 32'(out_valid), 32'd1);
    chk("t4_third_z", 32'(out_z), 32'd6);

    // 5: reset mid data frame with one result stored
    wait_phase(2'd3);
    in_valid = 1'b1; in_digit = 4'd7;
    chk("t5_acc", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_phase2", 32'(ser_phase), 32'd2);
    chk("t5_bit2", 32'(ser_x), 32'd1);
    chk("t5_stored", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ser_x", 32'(ser_x), 32'd0);
    chk("t5_rst_phase", 32'(ser_phase), 32'd0);
    chk("t5_rst_done", 32'(done_cnt), 32'd0);
    chk("t5_rst_out_z", 32'(out_z), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wait_phase(2'd3);
    in_valid = 1'b1; in_digit = 4'd8;
    chk("t5_credit1", 32'(in_ready), 32'd1);
    @(negedge clk);
    wait_phase(2'd3);
    in_digit = 4'd9;
    chk("t5_credit2", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("t5_no_stale", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t5_valid8", 32'(out_valid), 32'd1);
    chk("t5_z8", 32'(out_z), 32'd11);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_valid9", 32'(out_valid), 32'd1);
    chk("t5_z9", 32'(out_z), 32'd12);
    @(negedge clk); out_ready = 1'b0;
    chk("t5_done_cnt", 32'(done_cnt), 32'd2);
    chk("t5_empty", 32'(out_valid), 32'd0);

    // 6: out-of-range digit then 9
    wait_phase(2'd3);
    in_valid = 1'b1; in_digit = 4'd12;
    chk("t6_acc12", 32'(in_ready), 32'd1);
    @(negedge clk); in_digit = 4'd9;
    wait_phase(2'd3);
    chk("t6_acc9", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_valid12", 32'(out_valid), 32'd1);
    chk("t6_z12", 32'(out_z), 32'd15);
    chk("t6_err12", 32'(out_err), 32'(exp_err12));
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("t6_gap", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("t6_valid9", 32'(out_valid), 32'd1);
    chk("t6_z9", 32'(out_z), 32'd12);
    chk("t6_err9", 32'(out_err), 32'd0);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("t6_done_cnt", 32'(done_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
